// File: rtl/mac_kernel_sequencer.sv
// mac_kernel_sequencer: buffers one kernel window of signed operand pairs,
// streams them into a dsp_multiplier with clken control, and accumulates the
// returning products with saturation into a valid/ready window sum.
module mac_kernel_sequencer #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int DEPTH   = 9,
    parameter int MUL_LAT = 1,
    parameter int ACC_W   = 18
) (
    input  logic              clock,
    input  logic              aclr,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_a,
    input  logic [DATA_W-1:0] load_b,
    input  logic [DATA_W-1:0] bias,
    output logic              busy,
    output logic [DATA_W-1:0] mul_dataa,
    output logic [DATA_W-1:0] mul_datab,
    output logic [DATA_W-1:0] mul_sumin,
    output logic              mul_clken,
    input  logic [RES_W-1:0]  mul_result,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);
    localparam int DW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef enum logic [2:0] {IDLE, LOAD, ISSUE, DRAIN, OUTPUT} state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] buf_a [DEPTH];
    logic [DATA_W-1:0] buf_b [DEPTH];

    logic [CW-1:0]      cnt;
    logic [IW-1:0]      idx;
    logic [IW-1:0]      idx_nxt;
    logic [DW-1:0]      dcnt;
    logic [ACC_W-1:0]   acc;
    logic [MUL_LAT-1:0] vld_pipe;
    logic               vld_in;

    logic accept, last_acc, issue_last, drain_last;
    logic [ACC_W:0] sum_w;
    logic [ACC_W-1:0] sum_sat;

    assign accept     = load_valid && load_ready;
    assign last_acc   = accept && (cnt == CW'(DEPTH - 1));
    assign issue_last = (idx == IW'(DEPTH - 1));
    assign drain_last = (dcnt == DW'(MUL_LAT - 1));
    assign idx_nxt    = idx + IW'(1);

    // One extra bit of headroom: a single RES_W add cannot overflow ACC_W+1,
    // so a mismatch of the top two bits identifies the saturation direction.
    assign sum_w = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'($signed(mul_result));

    // Clamp the widened sum back into ACC_W signed range
    always_comb begin
        sum_sat = sum_w[ACC_W-1:0];
        if (sum_w[ACC_W] != sum_w[ACC_W-1])
            sum_sat = sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    // State register
    always_ff @(posedge clock) begin
        if (aclr) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state and control outputs
    always_comb begin
        state_d    = state_q;
        load_ready = 1'b0;
        busy       = 1'b0;
        mul_clken  = 1'b0;
        out_valid  = 1'b0;
        vld_in     = 1'b0;
        out_sum    = '0;
        unique case (state_q)
            IDLE: begin
                load_ready = !aclr;
                if (accept) state_d = last_acc ? ISSUE : LOAD;
            end
            LOAD: begin
                load_ready = !aclr;
                if (last_acc) state_d = ISSUE;
            end
            ISSUE: begin
                busy      = 1'b1;
                mul_clken = 1'b1;
                vld_in    = 1'b1;
                if (issue_last) state_d = DRAIN;
            end
            DRAIN: begin
                busy      = 1'b1;
                mul_clken = 1'b1;
                if (drain_last) state_d = OUTPUT;
            end
            OUTPUT: begin
                out_valid = 1'b1;
                out_sum   = acc;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand buffer; writes only on an accepted pair, so stray load_valid is harmless
    always_ff @(posedge clock) begin
        if (accept) begin
            buf_a[IW'(cnt)] <= load_a;
            buf_b[IW'(cnt)] <= load_b;
        end
    end

    // Counters, registered multiplier operands, valid pipe and accumulator
    always_ff @(posedge clock) begin
        if (aclr) begin
            cnt       <= '0;
            idx       <= '0;
            dcnt      <= '0;
            acc       <= '0;
            vld_pipe  <= '0;
            mul_dataa <= '0;
            mul_datab <= '0;
            mul_sumin <= '0;
        end else begin
            if (accept)
                cnt <= cnt + CW'(1);
            if (state_q == OUTPUT && out_ready)
                cnt <= '0;

            // Operands are registered one edge ahead so cycle k of ISSUE sees pair k
            if (last_acc) begin
                idx       <= '0;
                mul_dataa <= buf_a[0];
                mul_datab <= buf_b[0];
                mul_sumin <= bias;
            end else if (state_q == ISSUE) begin
                mul_sumin <= '0;
                if (issue_last) begin
                    dcnt      <= '0;
                    mul_dataa <= '0;
                    mul_datab <= '0;
                end else begin
                    idx       <= idx_nxt;
                    mul_dataa <= buf_a[idx_nxt];
                    mul_datab <= buf_b[idx_nxt];
                end
            end else if (state_q == DRAIN) begin
                dcnt <= dcnt + DW'(1);
            end

            // Valid pipe tracks the multiplier pipeline, so it only moves with clken
            if (mul_clken)
                vld_pipe <= MUL_LAT'({vld_pipe, vld_in});

            if (vld_pipe[MUL_LAT-1])
                acc <= sum_sat;
            if (last_acc)
                acc <= '0;
        end
    end

endmodule

// File: tb/tb_mac_kernel_sequencer.sv
// Directed bench for mac_kernel_sequencer with a one-stage dsp_multiplier model.
module tb_mac_kernel_sequencer;

    logic        clock = 1'b0;
    logic        aclr;
    logic        load_valid;
    logic        load_ready;
    logic [7:0]  load_a, load_b, bias;
    logic        busy;
    logic [7:0]  mul_dataa, mul_datab, mul_sumin;
    logic        mul_clken;
    logic [15:0] mul_result = '0;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] out_sum;

    int nvec = 0;
    int nerr = 0;
    int va [9];
    int vb [9];
    int lat;
    bit seen;

    mac_kernel_sequencer dut (
        .clock(clock), .aclr(aclr),
        .load_valid(load_valid), .load_ready(load_ready),
        .load_a(load_a), .load_b(load_b), .bias(bias),
        .busy(busy),
        .mul_dataa(mul_dataa), .mul_datab(mul_datab), .mul_sumin(mul_sumin),
        .mul_clken(mul_clken), .mul_result(mul_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
    );

    always #5 clock = ~clock;

    // dsp_multiplier model, latency 1, holds when clken is low
    always @(posedge clock)
        if (mul_clken)
            mul_result <= 16'(int'($signed(mul_dataa)) * int'($signed(mul_datab))
                              + int'($signed(mul_sumin)));

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat18(input int v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return v;
    endfunction

    function automatic int ref_sum(input int bv);
        int acc = 0;
        for (int k = 0; k < 9; k++)
            acc = sat18(acc + va[k] * vb[k] + ((k == 0) ? bv : 0));
        return acc;
    endfunction

    // Present the nine pairs in va/vb; gap inserts an idle cycle between pairs
    task automatic load_window(input int bv, input bit gap);
        for (int k = 0; k < 9; k++) begin
            load_valid = 1'b1;
            load_a = 8'(va[k]);
            load_b = 8'(vb[k]);
            bias   = 8'(bv);
            tick();
            load_valid = 1'b0;
            if (gap && k < 8) begin
                load_a = 8'h55;
                load_b = 8'h55;
                tick();
            end
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
    endtask

    function automatic int sum_s();
        return int'($signed(out_sum));
    endfunction

    initial begin
        aclr = 1'b1; load_valid = 1'b0; load_a = '0; load_b = '0; bias = '0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_load_ready", int'(load_ready), 0);
        chk("rst_busy",       int'(busy), 0);
        chk("rst_clken",      int'(mul_clken), 0);
        chk("rst_out_valid",  int'(out_valid), 0);
        chk("rst_out_sum",    sum_s(), 0);
        chk("rst_dataa",      int'(mul_dataa), 0);
        aclr = 1'b0;
        tick();
        chk("idle_load_ready", int'(load_ready), 1);

        // Window 1: 1*2 x9 + 3 = 21, latency 10, one-cycle valid
        out_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin va[k] = 1; vb[k] = 2; end
        load_window(3, 1'b0);
        chk("issue_busy",       int'(busy), 1);
        chk("issue_load_ready", int'(load_ready), 0);
        chk("issue_clken",      int'(mul_clken), 1);
        chk("issue0_dataa",     int'(mul_dataa), 1);
        chk("issue0_datab",     int'(mul_datab), 2);
        chk("issue0_sumin",     int'(mul_sumin), 3);
        tick();
        chk("issue1_sumin",     int'(mul_sumin), 0);
        wait_valid(lat);
        chk("w1_latency",  lat + 1, 10);
        chk("w1_valid",    int'(out_valid), 1);
        chk("w1_clken",    int'(mul_clken), 0);
        chk("w1_sum",      sum_s(), 21);
        tick();
        chk("w1_valid_1cyc", int'(out_valid), 0);
        chk("w1_idle_ready", int'(load_ready), 1);

        // Window 2: saturate high
        for (int k = 0; k < 9; k++) begin va[k] = -128; vb[k] = -128; end
        load_window(0, 1'b0);
        wait_valid(lat);
        chk("w2_valid", int'(out_valid), 1);
        chk("w2_sum_sat_hi", sum_s(), 131071);
        tick();

        // Window 3: saturate low
        for (int k = 0; k < 9; k++) begin va[k] = -128; vb[k] = 127; end
        load_window(-1, 1'b0);
        wait_valid(lat);
        chk("w3_valid", int'(out_valid), 1);
        chk("w3_sum_sat_lo", sum_s(), -131072);
        tick();

        // Window 4: back-pressure, sum held stable
        out_ready = 1'b0;
        for (int k = 0; k < 9; k++) begin va[k] = k - 4; vb[k] = 3; end
        load_window(5, 1'b0);
        wait_valid(lat);
        chk("w4_valid", int'(out_valid), 1);
        chk("w4_sum",   sum_s(), 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("w4_hold_valid", int'(out_valid), 1);
            chk("w4_hold_sum",   sum_s(), 5);
            chk("w4_hold_ready", int'(load_ready), 0);
        end
        out_ready = 1'b1;
        tick();
        chk("w4_cleared", int'(out_valid), 0);

        // Window 5: reset in ISSUE cycle 4 discards the window
        for (int k = 0; k < 9; k++) begin va[k] = 2; vb[k] = k + 1; end
        load_window(0, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        chk("w5_issue4_datab", int'(mul_datab), 5);
        aclr = 1'b1;
        tick();
        aclr = 1'b0;
        chk("w5_rst_clken", int'(mul_clken), 0);
        chk("w5_rst_busy",  int'(busy), 0);
        chk("w5_rst_dataa", int'(mul_dataa), 0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        chk("w5_no_valid", int'(seen), 0);
        for (int k = 0; k < 9; k++) begin va[k] = 1; vb[k] = 1; end
        load_window(0, 1'b0);
        wait_valid(lat);
        chk("w5_fresh_valid", int'(out_valid), 1);
        chk("w5_fresh_sum",   sum_s(), 9);
        tick();

        // Window 6: toggled load_valid during LOAD, stray load_valid in ISSUE
        for (int k = 0; k < 9; k++) begin va[k] = k * 7 - 30; vb[k] = 5 - k; end
        load_window(-7, 1'b1);
        load_valid = 1'b1; load_a = 8'd100; load_b = 8'd100;
        for (int i = 0; i < 3; i++) begin
            chk("w6_issue_ready", int'(load_ready), 0);
            tick();
        end
        load_valid = 1'b0;
        wait_valid(lat);
        chk("w6_valid", int'(out_valid), 1);
        chk("w6_sum",   sum_s(), ref_sum(-7));
        tick();
        chk("w6_cleared", int'(out_valid), 0);

        // Follow-up window confirms the load count restarted cleanly
        for (int k = 0; k < 9; k++) begin va[k] = 1; vb[k] = 1; end
        load_window(0, 1'b0);
        wait_valid(lat);
        chk("w7_valid", int'(out_valid), 1);
        chk("w7_sum",   sum_s(), 9);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
